// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared widths, receiver FSM state encoding and the Hamming(7,4)
//   syndrome function for the nibble-link receive path.
//   Codeword bit cw[i] is Hamming position i+1. Positions 1, 2 and 4 hold
//   parity. Positions 3, 5, 6 and 7 hold d0..d3.
package hamming_pkg;

   localparam int CW_W   = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      DECODE = 3'd4
   } rx_state_e;

   // Returns {s4,s2,s1}. A non-zero value is the 1-based position of the bad bit.
   function automatic logic [SYN_W-1:0] hamming74_syndrome(input logic [CW_W-1:0] cw);
      logic s1;
      logic s2;
      logic s4;
      s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
      s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      return {s4, s2, s1};
   endfunction

endpackage

// File: rtl/hamming74_decode_core.sv
// hamming74_decode_core
//   Purely combinational Hamming(7,4) single-error corrector.
//   Ports:
//     cw_in    in  7 : received codeword, cw_in[i] = position i+1
//     cw_corr  out 7 : codeword with the indicated bit inverted
//     data     out 4 : corrected payload {d3,d2,d1,d0}
//     syndrome out 3 : {s4,s2,s1}; 0 means no error was seen
module hamming74_decode_core
   import hamming_pkg::*;
(
   input  logic [CW_W-1:0]   cw_in,
   output logic [CW_W-1:0]   cw_corr,
   output logic [DATA_W-1:0] data,
   output logic [SYN_W-1:0]  syndrome
);

   always_comb begin
      syndrome = hamming74_syndrome(cw_in);
      cw_corr  = cw_in;
      for (int i = 0; i < CW_W; i++) begin
         if (syndrome == SYN_W'(i + 1)) begin
            cw_corr[i] = ~cw_in[i];
         end
      end
      data = {cw_corr[6], cw_corr[5], cw_corr[4], cw_corr[2]};
   end

endmodule

// File: rtl/hamming_rx_serial.sv
// hamming_rx_serial
//   UART-style receiver for one Hamming(7,4) codeword per frame
//   (start 0, cw[0]..cw[6] LSB first, stop 1). It corrects single-bit
//   errors and presents the payload with a one-cycle valid strobe.
//   Parameters:
//     CLKS_PER_BIT : clocks per serial bit (even, >= 4)
//     CNT_W        : width of the saturating correction counter
//   Ports:
//     clk           in  1     : system clock
//     rst           in  1     : asynchronous active-high reset
//     rx            in  1     : serial line, asynchronous, idles high
//     data_out      out 4     : corrected payload, held between frames
//     data_valid    out 1     : one-cycle pulse when data_out updates
//     err_corrected out 1     : last accepted frame needed a correction
//     syndrome      out 3     : {s4,s2,s1} of last accepted frame
//     frame_err     out 1     : one-cycle pulse on a low stop bit
//     corr_count    out CNT_W : corrected-frame count, saturating
module hamming_rx_serial
   import hamming_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              err_corrected,
   output logic [SYN_W-1:0]  syndrome,
   output logic              frame_err,
   output logic [CNT_W-1:0]  corr_count
);

   localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_CNT_W-1:0] FULL_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 rx_s;

   rx_state_e            state_q, state_d;
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [CW_W-1:0]      cw_q, cw_d;

   logic [DATA_W-1:0]    data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 err_q, err_d;
   logic [SYN_W-1:0]     syn_q, syn_d;
   logic                 frame_err_q, frame_err_d;
   logic [CNT_W-1:0]     corr_count_q, corr_count_d;

   logic [CW_W-1:0]      core_cw_corr;
   logic [DATA_W-1:0]    core_data;
   logic [SYN_W-1:0]     core_syn;
   logic                 stop_sample;

   assign rx_s = sync2_q;

   hamming74_decode_core u_core (
      .cw_in    (cw_q),
      .cw_corr  (core_cw_corr),
      .data     (core_data),
      .syndrome (core_syn)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, bit timing and shift register
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      cw_d      = cw_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               // A start bit that is high again at mid-bit is treated as a glitch.
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d     = '0;
               // Bits arrive LSB first, so shifting in at the top leaves cw[0] at bit 0.
               cw_d      = {rx_s, cw_q[CW_W-1:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd6) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               state_d = rx_s ? DECODE : IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DECODE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output registers are loaded on the edge that enters DECODE, so the
   // strobe and the new payload are visible during the DECODE cycle, one
   // cycle after the stop sample.
   always_comb begin
      stop_sample  = (state_q == STOP) && (cnt_q == FULL_LAST);
      data_valid_d = stop_sample && rx_s;
      frame_err_d  = stop_sample && !rx_s;
      data_out_d   = data_out_q;
      err_d        = err_q;
      syn_d        = syn_q;
      corr_count_d = corr_count_q;
      if (data_valid_d) begin
         data_out_d = core_data;
         err_d      = (core_cw_corr != cw_q);
         syn_d      = core_syn;
         if ((core_syn != '0) && (corr_count_q != {CNT_W{1'b1}})) begin
            corr_count_d = corr_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         cw_q         <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         err_q        <= 1'b0;
         syn_q        <= '0;
         frame_err_q  <= 1'b0;
         corr_count_q <= '0;
      end else begin
         sync1_q      <= rx;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         cw_q         <= cw_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         err_q        <= err_d;
         syn_q        <= syn_d;
         frame_err_q  <= frame_err_d;
         corr_count_q <= corr_count_d;
      end
   end

   assign data_out      = data_out_q;
   assign data_valid    = data_valid_q;
   assign err_corrected = err_q;
   assign syndrome      = syn_q;
   assign frame_err     = frame_err_q;
   assign corr_count    = corr_count_q;

endmodule

// File: tb/tb_hamming_rx_serial.sv
// tb_hamming_rx_serial
//   Directed bench for hamming_rx_serial. Every frame sent pushes its
//   expected outcome (strobe cycle, kind, payload, status, count) onto a
//   scoreboard queue; a negedge monitor pops and compares on every
//   data_valid / frame_err strobe.
module tb_hamming_rx_serial;

   localparam int C     = 16;
   localparam int H     = C / 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rx  = 1'b1;
   logic [3:0]       data_out;
   logic             data_valid;
   logic             err_corrected;
   logic [2:0]       syndrome;
   logic             frame_err;
   logic [CNT_W-1:0] corr_count;

   hamming_rx_serial #(
      .CLKS_PER_BIT (C),
      .CNT_W        (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .err_corrected (err_corrected),
      .syndrome      (syndrome),
      .frame_err     (frame_err),
      .corr_count    (corr_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int         cyc;
      logic       fe;
      logic [3:0] data;
      logic       err;
      logic [2:0] syn;
      logic [7:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [3:0] m_data = '0;
   logic [2:0] m_syn  = '0;
   logic       m_err  = 1'b0;
   logic [7:0] m_cnt  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decoder: syndrome as XOR of the positions of all set bits.
   function automatic void model(input logic [6:0] cw, output logic [3:0] d, output logic [2:0] s);
      logic [6:0] c;
      int         idx;
      s = '0;
      for (int i = 0; i < 7; i++) begin
         if (cw[i]) s = s ^ 3'(i + 1);
      end
      c = cw;
      if (s != 3'd0) begin
         idx = int'(s) - 1;
         c[idx] = ~c[idx];
      end
      d = {c[6], c[5], c[4], c[2]};
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p1, p2, p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction

   // Called at posedge+1; leaves the caller at posedge+1.
   task automatic send_bit(input logic b);
      rx = b;
      repeat (C) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1. The start edge on the pin reaches rx_s two edges
   // later, so the strobe is due 3+H+8C edges after this point.
   task automatic send_frame(input logic [6:0] cw, input logic stop_b);
      exp_t       e;
      logic [3:0] d;
      logic [2:0] s;
      model(cw, d, s);
      e.cyc = cyc + 3 + H + 8 * C;
      if (stop_b) begin
         m_data = d;
         m_syn  = s;
         m_err  = (s != 3'd0);
         if (s != 3'd0 && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         e.fe = 1'b0;
      end else begin
         e.fe = 1'b1;
      end
      e.data = m_data;
      e.err  = m_err;
      e.syn  = m_syn;
      e.cnt  = m_cnt;
      q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(cw[i]);
      send_bit(stop_b);
      rx = 1'b1;
   endtask

   task automatic check_reset();
      chk("rst_data_out",   {28'b0, data_out},      32'h0);
      chk("rst_data_valid", {31'b0, data_valid},    32'h0);
      chk("rst_err",        {31'b0, err_corrected}, 32'h0);
      chk("rst_syndrome",   {29'b0, syndrome},      32'h0);
      chk("rst_frame_err",  {31'b0, frame_err},     32'h0);
      chk("rst_corr_count", {24'b0, corr_count},    32'h0);
   endtask

   always @(negedge clk) begin
      if (!rst && (data_valid === 1'b1 || frame_err === 1'b1)) begin
         chk("dv_fe_overlap", {31'b0, data_valid & frame_err}, 32'h0);
         if (q.size() == 0) begin
            chk("unexpected_event", {30'b0, data_valid, frame_err}, 32'h0);
         end else begin
            mon_e = q.pop_front();
            chk("event_cycle",   cyc,                     mon_e.cyc);
            chk("frame_err",     {31'b0, frame_err},      {31'b0, mon_e.fe});
            chk("data_valid",    {31'b0, data_valid},     {31'b0, ~mon_e.fe});
            chk("data_out",      {28'b0, data_out},       {28'b0, mon_e.data});
            chk("err_corrected", {31'b0, err_corrected},  {31'b0, mon_e.err});
            chk("syndrome",      {29'b0, syndrome},       {29'b0, mon_e.syn});
            chk("corr_count",    {24'b0, corr_count},     {24'b0, mon_e.cnt});
         end
      end
   end

   initial begin
      #(90000 * 10);
      $display("FAIL timeout cycle=%0d pending=%0d", cyc, q.size());
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [6:0] cw;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      idle(5);

      // Clean frame: payload B, no correction.
      send_frame(7'h55, 1'b1);
      idle(C);

      // Each single-bit error position must be reported and corrected.
      for (int p = 0; p < 7; p++) begin
         cw = 7'h55 ^ (7'd1 << p);
         send_frame(cw, 1'b1);
         idle(4);
      end
      idle(C);

      // Low stop bit: frame_err only, outputs held.
      send_frame(7'h55, 1'b0);
      idle(2 * C);

      // Short low pulse rejected at the start-bit midpoint.
      rx = 1'b0;
      idle(6);
      rx = 1'b1;
      idle(3 * C);
      chk("glitch_no_event", q.size(), 32'h0);

      // Receiver still usable after the glitch.
      send_frame(encode(4'h3), 1'b1);
      idle(C);

      // Reset in the middle of data bit 3 discards the partial frame.
      chk("queue_empty_pre_rst", q.size(), 32'h0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rx = 1'b0;
      idle(H);
      rst = 1'b1;
      rx  = 1'b1;
      idle(2);
      @(negedge clk);
      check_reset();
      m_data = '0;
      m_syn  = '0;
      m_err  = 1'b0;
      m_cnt  = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      idle(C);
      send_frame(7'h55, 1'b1);
      idle(C);

      // Back-to-back single-error frames drive the counter into saturation.
      for (int n = 0; n < 300; n++) begin
         cw = encode(4'($urandom_range(0, 15))) ^ (7'd1 << $urandom_range(0, 6));
         send_frame(cw, 1'b1);
      end

      for (int i = 0; i < 4 * C && q.size() != 0; i++) @(posedge clk);
      chk("queue_drained", q.size(), 32'h0);
      @(negedge clk);
      chk("corr_count_saturated", {24'b0, corr_count}, 32'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
